// File: rtl/ant_engine_if.sv
// Bus between the ant engine, the sprite renderer and the display scan.
// The engine takes the slave side; the renderer/scan (or a bench) the master side.
`timescale 1ns/1ps
interface ant_engine_if #(
   parameter int CW = 3
);
   logic          istep;
   logic [CW-1:0] line;
   logic [CW-1:0] column;
   logic          ocell;
   logic [CW-1:0] cur_pos_x;
   logic [CW-1:0] cur_pos_y;
   logic [1:0]    direction;
   logic          obusy;
   logic [31:0]   ostep_cnt;

   modport master (
      output istep, line, column,
      input  ocell, cur_pos_x, cur_pos_y, direction, obusy, ostep_cnt
   );

   modport slave (
      input  istep, line, column,
      output ocell, cur_pos_x, cur_pos_y, direction, obusy, ostep_cnt
   );
endinterface

// File: rtl/ant_engine.sv
// Langton's-ant state engine: one-bit-per-cell colour grid, ant position and
// heading, a step FSM (CLEAR -> IDLE -> LOOK -> TURN -> MOVE -> IDLE) and a
// registered read-only port for the display scan.
`timescale 1ns/1ps
module ant_engine #(
   parameter int C_NUM_OF_CELLS_X = 5,
   parameter int C_NUM_OF_CELLS_Y = 5,
   parameter int C_START_X        = 2,
   parameter int C_START_Y        = 2,
   parameter int C_START_DIR      = 0
) (
   input  logic         iclk,
   input  logic         irst_n,
   ant_engine_if.slave  bus
);

   localparam int CW    = $clog2((C_NUM_OF_CELLS_X + C_NUM_OF_CELLS_Y) / 2);
   localparam int NCELL = C_NUM_OF_CELLS_X * C_NUM_OF_CELLS_Y;
   localparam int AW    = $clog2(NCELL);

   localparam logic [CW-1:0] X_MAX     = CW'(C_NUM_OF_CELLS_X - 1);
   localparam logic [CW-1:0] Y_MAX     = CW'(C_NUM_OF_CELLS_Y - 1);
   localparam logic [CW-1:0] START_X   = CW'(C_START_X);
   localparam logic [CW-1:0] START_Y   = CW'(C_START_Y);
   localparam logic [1:0]    START_DIR = 2'(C_START_DIR);
   // One extra bit so a dimension equal to 2**CW does not truncate to zero.
   localparam logic [CW:0]   X_LIM     = (CW+1)'(C_NUM_OF_CELLS_X);
   localparam logic [CW:0]   Y_LIM     = (CW+1)'(C_NUM_OF_CELLS_Y);
   localparam logic [AW-1:0] X_AW      = AW'(C_NUM_OF_CELLS_X);
   localparam logic [AW-1:0] LAST_ADDR = AW'(NCELL - 1);

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   typedef enum logic [2:0] {
      S_CLEAR = 3'd0,
      S_IDLE  = 3'd1,
      S_LOOK  = 3'd2,
      S_TURN  = 3'd3,
      S_MOVE  = 3'd4
   } state_t;

   // Heading after a clockwise quarter turn (ant on a white cell).
   function automatic logic [1:0] turn_right(input logic [1:0] dir);
      logic [1:0] res;
      case (dir)
         DIR_UP:    res = DIR_RIGHT;
         DIR_RIGHT: res = DIR_DOWN;
         DIR_DOWN:  res = DIR_LEFT;
         DIR_LEFT:  res = DIR_UP;
         default:   res = DIR_UP;
      endcase
      return res;
   endfunction

   // Heading after a counter-clockwise quarter turn (ant on a black cell).
   function automatic logic [1:0] turn_left(input logic [1:0] dir);
      logic [1:0] res;
      case (dir)
         DIR_UP:    res = DIR_LEFT;
         DIR_LEFT:  res = DIR_DOWN;
         DIR_DOWN:  res = DIR_RIGHT;
         DIR_RIGHT: res = DIR_UP;
         default:   res = DIR_UP;
      endcase
      return res;
   endfunction

   state_t          state_q, state_d;
   logic [AW-1:0]   clr_addr_q, clr_addr_d;
   logic [CW-1:0]   pos_x_q, pos_x_d;
   logic [CW-1:0]   pos_y_q, pos_y_d;
   logic [1:0]      dir_q, dir_d;
   logic [31:0]     cnt_q, cnt_d;
   logic            colour_q, colour_d;
   logic            busy_q, busy_d;
   logic [NCELL-1:0] grid_q;
   logic            ocell_q;

   logic            wr_en_s;
   logic [AW-1:0]   wr_addr_s;
   logic            wr_data_s;
   logic [AW-1:0]   cur_addr_s;
   logic [AW-1:0]   rd_addr_s;
   logic            rd_in_range_s;

   assign cur_addr_s    = AW'(pos_y_q) * X_AW + AW'(pos_x_q);
   assign rd_addr_s     = AW'(bus.line) * X_AW + AW'(bus.column);
   assign rd_in_range_s = ({1'b0, bus.column} < X_LIM) && ({1'b0, bus.line} < Y_LIM);

   // FSM state and ant registers; reset drops any step in flight back to CLEAR.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q    <= S_CLEAR;
         clr_addr_q <= {AW{1'b0}};
         pos_x_q    <= START_X;
         pos_y_q    <= START_Y;
         dir_q      <= START_DIR;
         cnt_q      <= 32'd0;
         colour_q   <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         dir_q      <= dir_d;
         cnt_q      <= cnt_d;
         colour_q   <= colour_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state, grid port-A write control and ant update for each FSM phase.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      dir_d      = dir_q;
      cnt_d      = cnt_q;
      colour_d   = colour_q;
      wr_en_s    = 1'b0;
      wr_addr_s  = cur_addr_s;
      wr_data_s  = 1'b0;

      case (state_q)
         S_CLEAR: begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_addr_q;
            wr_data_s = 1'b0;
            if (clr_addr_q == LAST_ADDR) begin
               clr_addr_d = {AW{1'b0}};
               state_d    = S_IDLE;
            end else begin
               clr_addr_d = clr_addr_q + AW'(1);
               state_d    = S_CLEAR;
            end
         end
         S_IDLE: begin
            if (bus.istep) begin
               state_d = S_LOOK;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOOK: begin
            colour_d = grid_q[cur_addr_s];
            state_d  = S_TURN;
         end
         S_TURN: begin
            wr_en_s = 1'b1;
            if (colour_q) begin
               dir_d     = turn_left(dir_q);
               wr_data_s = 1'b0;
            end else begin
               dir_d     = turn_right(dir_q);
               wr_data_s = 1'b1;
            end
            state_d = S_MOVE;
         end
         S_MOVE: begin
            case (dir_q)
               DIR_UP:    pos_y_d = (pos_y_q == {CW{1'b0}}) ? Y_MAX : pos_y_q - CW'(1);
               DIR_DOWN:  pos_y_d = (pos_y_q == Y_MAX) ? {CW{1'b0}} : pos_y_q + CW'(1);
               DIR_LEFT:  pos_x_d = (pos_x_q == {CW{1'b0}}) ? X_MAX : pos_x_q - CW'(1);
               DIR_RIGHT: pos_x_d = (pos_x_q == X_MAX) ? {CW{1'b0}} : pos_x_q + CW'(1);
               default:   pos_x_d = pos_x_q;
            endcase
            cnt_d   = cnt_q + 32'd1;
            state_d = S_IDLE;
         end
         default: begin
            state_d    = S_CLEAR;
            clr_addr_d = {AW{1'b0}};
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // Colour grid storage, written only through port A.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         grid_q <= {NCELL{1'b0}};
      end else if (wr_en_s) begin
         grid_q[wr_addr_s] <= wr_data_s;
      end
   end

   // Port B: registered display read; sees the pre-write colour on a same-cycle write.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         ocell_q <= 1'b0;
      end else if (rd_in_range_s) begin
         ocell_q <= grid_q[rd_addr_s];
      end else begin
         ocell_q <= 1'b0;
      end
   end

   assign bus.ocell     = ocell_q;
   assign bus.cur_pos_x = pos_x_q;
   assign bus.cur_pos_y = pos_y_q;
   assign bus.direction = dir_q;
   assign bus.obusy     = busy_q;
   assign bus.ostep_cnt = cnt_q;

endmodule

// File: tb/tb_ant_engine.sv
// Bench for ant_engine: step table with a scoreboard of expected ant states,
// plus hand-written sequences for clear length, wrap-around, dropped istep
// and reset in the middle of a step.
`timescale 1ns/1ps
module tb_ant_engine;
   localparam int CW = 3;
   localparam int NX = 5;
   localparam int NY = 5;

   logic iclk   = 1'b0;
   logic irst_n = 1'b0;
   always #5 iclk = ~iclk;

   ant_engine_if #(.CW(CW)) bus   ();
   ant_engine_if #(.CW(CW)) bus_r ();
   ant_engine_if #(.CW(CW)) bus_l ();

   ant_engine u_dut (.iclk(iclk), .irst_n(irst_n), .bus(bus));
   ant_engine #(.C_START_X(4), .C_START_DIR(0)) u_wrap_r (.iclk(iclk), .irst_n(irst_n), .bus(bus_r));
   ant_engine #(.C_START_X(0), .C_START_DIR(1)) u_wrap_l (.iclk(iclk), .irst_n(irst_n), .bus(bus_l));

   typedef struct packed {
      logic [2:0]  x;
      logic [2:0]  y;
      logic [1:0]  d;
      logic [31:0] cnt;
   } exp_t;

   exp_t vecs [5];
   exp_t sb_q [$];

   int   checks = 0;
   int   errors = 0;

   // bench model of the ant and grid
   int   m_x, m_y, m_d;
   bit   mgrid [NX*NY];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.obusy !== 1'b0 && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("FAIL %s idle wait expired actual=busy required=idle", name);
      end
   endtask

   task automatic pop_cmp(input string name);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s unexpected step completion actual=empty required=entry", name);
      end else begin
         e = sb_q.pop_front();
         chk({name, "_x"},   32'(bus.cur_pos_x), 32'(e.x));
         chk({name, "_y"},   32'(bus.cur_pos_y), 32'(e.y));
         chk({name, "_dir"}, 32'(bus.direction), 32'(e.d));
         chk({name, "_cnt"}, bus.ostep_cnt, e.cnt);
      end
   endtask

   // one table step with cycle-exact latency checks, port B watching the ant cell
   task automatic do_step(input int idx);
      exp_t e;
      bit   old_c;
      string nm;
      e  = vecs[idx];
      nm = $sformatf("step%0d", idx + 1);
      wait_idle(nm);
      bus.column = 3'(m_x);
      bus.line   = 3'(m_y);
      old_c = mgrid[m_y*NX + m_x];
      sb_q.push_back(e);
      bus.istep = 1'b1;
      tick();
      bus.istep = 1'b0;
      chk({nm, "_busy_t"}, 32'(bus.obusy), 32'd1);
      chk({nm, "_dir_t"},  32'(bus.direction), 32'(m_d));
      tick();
      chk({nm, "_dir_t1"}, 32'(bus.direction), 32'(m_d));
      chk({nm, "_x_t1"},   32'(bus.cur_pos_x), 32'(m_x));
      tick();
      chk({nm, "_dir_t2"},  32'(bus.direction), 32'(e.d));
      chk({nm, "_x_t2"},    32'(bus.cur_pos_x), 32'(m_x));
      chk({nm, "_y_t2"},    32'(bus.cur_pos_y), 32'(m_y));
      chk({nm, "_rdold_t2"}, 32'(bus.ocell), 32'(old_c));
      tick();
      chk({nm, "_rdnew_t3"}, 32'(bus.ocell), 32'(!old_c));
      chk({nm, "_busy_t3"},  32'(bus.obusy), 32'd0);
      pop_cmp(nm);
      mgrid[m_y*NX + m_x] = !old_c;
      m_x = int'(e.x);
      m_y = int'(e.y);
      m_d = int'(e.d);
   endtask

   // free-running stretch: istep high for n_hi cycles, pop on each busy fall
   task automatic run_cycles(input string name, input int n_hi, input int n_total);
      logic prev;
      for (int i = 0; i < n_total; i++) begin
         bus.istep = (i < n_hi) ? 1'b1 : 1'b0;
         prev = bus.obusy;
         tick();
         if (prev === 1'b1 && bus.obusy === 1'b0) pop_cmp(name);
      end
      bus.istep = 1'b0;
      chk({name, "_sb_left"}, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic read_cell(input int x, input int y, output logic v);
      bus.column = 3'(x);
      bus.line   = 3'(y);
      tick();
      v = bus.ocell;
   endtask

   task automatic clear_and_scan(input string name);
      int   n = 0;
      int   nz = 0;
      logic v;
      while (bus.obusy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk({name, "_clear_len"}, 32'(n), 32'd25);
      for (int y = 0; y < NY; y++) begin
         for (int x = 0; x < NX; x++) begin
            read_cell(x, y, v);
            if (v !== 1'b0) nz++;
         end
      end
      chk({name, "_cells_zero"}, 32'(nz), 32'd0);
      chk({name, "_x"},   32'(bus.cur_pos_x), 32'd2);
      chk({name, "_y"},   32'(bus.cur_pos_y), 32'd2);
      chk({name, "_dir"}, 32'(bus.direction), 32'd0);
      chk({name, "_cnt"}, bus.ostep_cnt, 32'd0);
   endtask

   task automatic model_reset();
      m_x = 2; m_y = 2; m_d = 0;
      for (int i = 0; i < NX*NY; i++) mgrid[i] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic v;
      vecs[0] = '{x: 3'd3, y: 3'd2, d: 2'd3, cnt: 32'd1};
      vecs[1] = '{x: 3'd3, y: 3'd3, d: 2'd1, cnt: 32'd2};
      vecs[2] = '{x: 3'd2, y: 3'd3, d: 2'd2, cnt: 32'd3};
      vecs[3] = '{x: 3'd2, y: 3'd2, d: 2'd0, cnt: 32'd4};
      vecs[4] = '{x: 3'd1, y: 3'd2, d: 2'd2, cnt: 32'd5};

      bus.istep = 1'b0;   bus.line = 3'd0;   bus.column = 3'd0;
      bus_r.istep = 1'b0; bus_r.line = 3'd0; bus_r.column = 3'd0;
      bus_l.istep = 1'b0; bus_l.line = 3'd0; bus_l.column = 3'd0;
      model_reset();

      // reset state
      repeat (3) tick();
      chk("rst_busy",  32'(bus.obusy), 32'd1);
      chk("rst_x",     32'(bus.cur_pos_x), 32'd2);
      chk("rst_y",     32'(bus.cur_pos_y), 32'd2);
      chk("rst_dir",   32'(bus.direction), 32'd0);
      chk("rst_cnt",   bus.ostep_cnt, 32'd0);
      chk("rst_ocell", 32'(bus.ocell), 32'd0);
      chk("rst_wr_x",  32'(bus_r.cur_pos_x), 32'd4);
      chk("rst_wl_dir", 32'(bus_l.direction), 32'd1);

      irst_n = 1'b1;
      clear_and_scan("boot");

      // wrap-around on the side instances
      bus_r.istep = 1'b1;
      bus_l.istep = 1'b1;
      tick();
      bus_r.istep = 1'b0;
      bus_l.istep = 1'b0;
      repeat (3) tick();
      chk("wrap_r_x",   32'(bus_r.cur_pos_x), 32'd0);
      chk("wrap_r_y",   32'(bus_r.cur_pos_y), 32'd2);
      chk("wrap_r_dir", 32'(bus_r.direction), 32'd3);
      chk("wrap_l_x",   32'(bus_l.cur_pos_x), 32'd4);
      chk("wrap_l_y",   32'(bus_l.cur_pos_y), 32'd2);
      chk("wrap_l_dir", 32'(bus_l.direction), 32'd2);
      chk("wrap_l_cnt", bus_l.ostep_cnt, 32'd1);

      // four table steps
      for (int i = 0; i < 4; i++) do_step(i);
      read_cell(2, 2, v); chk("cell_2_2", 32'(v), 32'd1);
      read_cell(3, 2, v); chk("cell_3_2", 32'(v), 32'd1);
      read_cell(3, 3, v); chk("cell_3_3", 32'(v), 32'd1);
      read_cell(2, 3, v); chk("cell_2_3", 32'(v), 32'd1);
      read_cell(1, 2, v); chk("cell_1_2", 32'(v), 32'd0);
      // out of range columns alias black cells if not masked
      read_cell(7, 2, v); chk("oor_col7_row2", 32'(v), 32'd0);
      read_cell(7, 1, v); chk("oor_col7_row1", 32'(v), 32'd0);
      read_cell(2, 5, v); chk("oor_row5", 32'(v), 32'd0);

      // fifth step from a black cell
      do_step(4);
      read_cell(2, 2, v); chk("step5_cell_2_2", 32'(v), 32'd0);
      chk("step5_cnt", bus.ostep_cnt, 32'd5);

      // reset asserted while in TURN
      wait_idle("midrst");
      bus.istep = 1'b1;
      tick();
      bus.istep = 1'b0;
      tick();
      irst_n = 1'b0;
      #1;
      chk("midrst_x",    32'(bus.cur_pos_x), 32'd2);
      chk("midrst_y",    32'(bus.cur_pos_y), 32'd2);
      chk("midrst_dir",  32'(bus.direction), 32'd0);
      chk("midrst_cnt",  bus.ostep_cnt, 32'd0);
      chk("midrst_busy", 32'(bus.obusy), 32'd1);
      chk("midrst_ocell", 32'(bus.ocell), 32'd0);
      repeat (2) tick();
      irst_n = 1'b1;
      clear_and_scan("midrst");
      model_reset();

      // istep pulses during busy are dropped
      wait_idle("pulse");
      sb_q.push_back(vecs[0]);
      run_cycles("pulse", 3, 12);
      chk("pulse_cnt", bus.ostep_cnt, 32'd1);

      // istep held high for 12 cycles: three steps
      wait_idle("held");
      sb_q.push_back(vecs[1]);
      sb_q.push_back(vecs[2]);
      sb_q.push_back(vecs[3]);
      run_cycles("held", 12, 20);
      chk("held_cnt", bus.ostep_cnt, 32'd4);
      chk("held_x",   32'(bus.cur_pos_x), 32'd2);
      chk("held_dir", 32'(bus.direction), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
